// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: register address width, the zero register and
// the EX forwarding-select encodings.
package pipeline_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/hazard_scoreboard_unit_mdu_scoreboard.sv
// Tracks the single in-flight MDU op: pending-register vector, latency
// countdown, busy/done flags and the captured destination.
module mdu_scoreboard #(
  parameter int REG_AW      = 5,
  parameter int NUM_REGS    = 32,
  parameter int MDU_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                issue,
  input  logic [REG_AW-1:0]   dst,
  output logic [NUM_REGS-1:0] pending,
  output logic                busy,
  output logic                done,
  output logic [REG_AW-1:0]   wb_addr
);
  import pipeline_pkg::*;

  // cnt holds the busy cycles still to run, including the current one
  localparam logic [3:0] LOAD = 4'(MDU_LATENCY - 1);

  logic [3:0]          cnt, cnt_nxt;
  logic                busy_nxt;
  logic [NUM_REGS-1:0] pend_nxt;

  always_comb begin
    busy_nxt = busy && !done;
    cnt_nxt  = cnt;
    if (issue) begin
      busy_nxt = 1'b1;
      cnt_nxt  = LOAD;
    end else if (busy && !done) begin
      cnt_nxt = cnt - 4'd1;
    end
  end

  // Retire clears first so a back-to-back issue to another register sticks
  always_comb begin
    pend_nxt = pending;
    if (done) pend_nxt[wb_addr] = 1'b0;
    if (issue && dst != REG_AW'(ZERO_REG)) pend_nxt[dst] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wb_addr <= '0;
      cnt     <= '0;
    end else begin
      pending <= pend_nxt;
      busy    <= busy_nxt;
      cnt     <= cnt_nxt;
      done    <= busy_nxt && (cnt_nxt == 4'd1);
      if (issue) wb_addr <= dst;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// Hazard/forwarding controller for the 5-stage pipeline with a one-op MDU
// scoreboard and a saturating stall-cycle counter.
module hazard_scoreboard_unit #(
  parameter int REG_AW      = 5,
  parameter int NUM_REGS    = 32,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] rs_dec,
  input  logic [REG_AW-1:0] rt_dec,
  input  logic              use_rs_dec,
  input  logic              use_rt_dec,
  input  logic              branch_dec,
  input  logic              mdu_start_dec,
  input  logic [REG_AW-1:0] mdu_dst_dec,
  input  logic              flush_dec,
  input  logic [REG_AW-1:0] rs_exe,
  input  logic [REG_AW-1:0] rt_exe,
  input  logic [REG_AW-1:0] regaddr_exe,
  input  logic              regwrite_exe,
  input  logic              memtoreg_exe,
  input  logic [REG_AW-1:0] regaddr_mem,
  input  logic              regwrite_mem,
  input  logic              memtoreg_mem,
  input  logic [REG_AW-1:0] regaddr_wb,
  input  logic              regwrite_wb,
  output logic              stall_pc,
  output logic              stall_decode,
  output logic              flush_exe,
  output logic              forwardA_decode,
  output logic              forwardB_decode,
  output logic [1:0]        forwardA_exe,
  output logic [1:0]        forwardB_exe,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [REG_AW-1:0] mdu_wb_addr,
  output logic [CNT_W-1:0]  stall_count
);
  import pipeline_pkg::*;

  logic [NUM_REGS-1:0] pending;
  logic lwstall, branchstall, sbstall, stall, issue;
  logic exe_nz, mem_nz;

  function automatic fwd_sel_e fwd_exe(input logic [REG_AW-1:0] src,
                                       input logic [REG_AW-1:0] mem_a, input logic mem_w,
                                       input logic [REG_AW-1:0] wb_a,  input logic wb_w);
    if (src != REG_AW'(ZERO_REG) && src == mem_a && mem_w) return FWD_MEM;
    if (src != REG_AW'(ZERO_REG) && src == wb_a && wb_w)   return FWD_WB;
    return FWD_RF;
  endfunction

  assign forwardA_exe = fwd_exe(rs_exe, regaddr_mem, regwrite_mem, regaddr_wb, regwrite_wb);
  assign forwardB_exe = fwd_exe(rt_exe, regaddr_mem, regwrite_mem, regaddr_wb, regwrite_wb);

  assign forwardA_decode = (rs_dec != REG_AW'(ZERO_REG)) && (rs_dec == regaddr_mem) && regwrite_mem;
  assign forwardB_decode = (rt_dec != REG_AW'(ZERO_REG)) && (rt_dec == regaddr_mem) && regwrite_mem;

  assign exe_nz = regaddr_exe != REG_AW'(ZERO_REG);
  assign mem_nz = regaddr_mem != REG_AW'(ZERO_REG);

  assign lwstall = memtoreg_exe && exe_nz &&
                   ((use_rs_dec && rs_dec == regaddr_exe) || (use_rt_dec && rt_dec == regaddr_exe));

  // Branch compares in ID, so an EX producer or a MEM load can't be forwarded yet
  assign branchstall = branch_dec &&
    ((regwrite_exe && exe_nz && (rs_dec == regaddr_exe || rt_dec == regaddr_exe)) ||
     (memtoreg_mem && mem_nz && (rs_dec == regaddr_mem || rt_dec == regaddr_mem)));

  assign sbstall = (use_rs_dec && pending[rs_dec]) ||
                   (use_rt_dec && pending[rt_dec]) ||
                   (mdu_start_dec && pending[mdu_dst_dec]) ||
                   (mdu_start_dec && mdu_busy && !mdu_done);

  assign stall        = lwstall | branchstall | sbstall;
  assign stall_pc     = stall;
  assign stall_decode = stall;
  assign flush_exe    = stall;
  assign issue        = mdu_start_dec && !stall && !flush_dec;

  mdu_scoreboard #(
    .REG_AW      (REG_AW),
    .NUM_REGS    (NUM_REGS),
    .MDU_LATENCY (MDU_LATENCY)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue),
    .dst     (mdu_dst_dec),
    .pending (pending),
    .busy    (mdu_busy),
    .done    (mdu_done),
    .wb_addr (mdu_wb_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_count <= '0;
    else if (stall && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed scenarios plus randomized traffic against a transaction-level
// model of the hazard unit (one in-flight MDU op tracked as "cycles left").
module tb_hazard_scoreboard_unit;
  localparam int AW = 5, LAT = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [AW-1:0] rs_dec, rt_dec, mdu_dst_dec, rs_exe, rt_exe, regaddr_exe, regaddr_mem, regaddr_wb;
  logic use_rs_dec, use_rt_dec, branch_dec, mdu_start_dec, flush_dec;
  logic regwrite_exe, memtoreg_exe, regwrite_mem, memtoreg_mem, regwrite_wb;
  logic stall_pc, stall_decode, flush_exe, fa_d, fb_d, busy, done;
  logic [1:0] fa_e, fb_e;
  logic [AW-1:0] wb_addr;
  logic [31:0] cnt;
  logic s_pc, s_dec, s_fl, s_fad, s_fbd, s_busy, s_done;
  logic [1:0] s_fae, s_fbe;
  logic [AW-1:0] s_addr;
  logic [2:0] cnt3;

  int checks = 0, errors = 0;

  // model state
  int m_rem = 0;
  logic [AW-1:0] m_addr = '0;
  longint m_cnt = 0;
  int m_cnt3 = 0;
  bit e_stall, e_fa_d, e_fb_d, e_busy, e_done;
  logic [1:0] e_fa_e, e_fb_e;
  logic [AW-1:0] e_addr;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(.REG_AW(AW), .NUM_REGS(32), .MDU_LATENCY(LAT), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .rs_dec(rs_dec), .rt_dec(rt_dec), .use_rs_dec(use_rs_dec),
    .use_rt_dec(use_rt_dec), .branch_dec(branch_dec), .mdu_start_dec(mdu_start_dec),
    .mdu_dst_dec(mdu_dst_dec), .flush_dec(flush_dec), .rs_exe(rs_exe), .rt_exe(rt_exe),
    .regaddr_exe(regaddr_exe), .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe),
    .regaddr_mem(regaddr_mem), .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
    .regaddr_wb(regaddr_wb), .regwrite_wb(regwrite_wb), .stall_pc(stall_pc),
    .stall_decode(stall_decode), .flush_exe(flush_exe), .forwardA_decode(fa_d),
    .forwardB_decode(fb_d), .forwardA_exe(fa_e), .forwardB_exe(fb_e), .mdu_busy(busy),
    .mdu_done(done), .mdu_wb_addr(wb_addr), .stall_count(cnt));

  hazard_scoreboard_unit #(.REG_AW(AW), .NUM_REGS(32), .MDU_LATENCY(LAT), .CNT_W(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .rs_dec(rs_dec), .rt_dec(rt_dec), .use_rs_dec(use_rs_dec),
    .use_rt_dec(use_rt_dec), .branch_dec(branch_dec), .mdu_start_dec(mdu_start_dec),
    .mdu_dst_dec(mdu_dst_dec), .flush_dec(flush_dec), .rs_exe(rs_exe), .rt_exe(rt_exe),
    .regaddr_exe(regaddr_exe), .regwrite_exe(regwrite_exe), .memtoreg_exe(memtoreg_exe),
    .regaddr_mem(regaddr_mem), .regwrite_mem(regwrite_mem), .memtoreg_mem(memtoreg_mem),
    .regaddr_wb(regaddr_wb), .regwrite_wb(regwrite_wb), .stall_pc(s_pc),
    .stall_decode(s_dec), .flush_exe(s_fl), .forwardA_decode(s_fad),
    .forwardB_decode(s_fbd), .forwardA_exe(s_fae), .forwardB_exe(s_fbe), .mdu_busy(s_busy),
    .mdu_done(s_done), .mdu_wb_addr(s_addr), .stall_count(cnt3));

  function automatic bit pend(input logic [AW-1:0] r);
    return m_rem > 0 && r == m_addr && r != 0;
  endfunction

  function automatic logic [1:0] fwd(input logic [AW-1:0] s);
    if (s != 0 && s == regaddr_mem && regwrite_mem) return 2'b10;
    if (s != 0 && s == regaddr_wb && regwrite_wb) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_eval();
    bit lw, br, sb;
    lw = memtoreg_exe && regaddr_exe != 0 &&
         ((use_rs_dec && rs_dec == regaddr_exe) || (use_rt_dec && rt_dec == regaddr_exe));
    br = branch_dec && ((regwrite_exe && regaddr_exe != 0 && (rs_dec == regaddr_exe || rt_dec == regaddr_exe)) ||
                        (memtoreg_mem && regaddr_mem != 0 && (rs_dec == regaddr_mem || rt_dec == regaddr_mem)));
    sb = (use_rs_dec && pend(rs_dec)) || (use_rt_dec && pend(rt_dec)) ||
         (mdu_start_dec && pend(mdu_dst_dec)) || (mdu_start_dec && m_rem > 1);
    e_stall = lw | br | sb;
    e_fa_d = rs_dec != 0 && rs_dec == regaddr_mem && regwrite_mem;
    e_fb_d = rt_dec != 0 && rt_dec == regaddr_mem && regwrite_mem;
    e_fa_e = fwd(rs_exe);
    e_fb_e = fwd(rt_exe);
    e_busy = m_rem > 0;
    e_done = m_rem == 1;
    e_addr = m_addr;
  endtask

  task automatic model_step();
    model_eval();
    if (!rst_n) begin
      m_rem = 0; m_addr = '0; m_cnt = 0; m_cnt3 = 0;
      return;
    end
    if (e_stall) begin
      if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
      if (m_cnt3 < 7) m_cnt3++;
    end
    if (mdu_start_dec && !e_stall && !flush_dec) begin
      m_rem = LAT - 1;
      m_addr = mdu_dst_dec;
    end else if (m_rem > 0) m_rem--;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle();
    {rs_dec, rt_dec, mdu_dst_dec, rs_exe, rt_exe, regaddr_exe, regaddr_mem, regaddr_wb} = '0;
    {use_rs_dec, use_rt_dec, branch_dec, mdu_start_dec, flush_dec} = '0;
    {regwrite_exe, memtoreg_exe, regwrite_mem, memtoreg_mem, regwrite_wb} = '0;
  endtask

  task automatic test_reset();
    idle(); #2;
    checks++; if ({stall_pc, stall_decode, flush_exe, fa_d, fb_d, fa_e, fb_e} !== 9'd0) begin errors++; $display("FAIL reset_ctl got %b want 0", {stall_pc, stall_decode, flush_exe, fa_d, fb_d, fa_e, fb_e}); end
    checks++; if ({busy, done, wb_addr} !== 7'd0) begin errors++; $display("FAIL reset_mdu got %b want 0", {busy, done, wb_addr}); end
    checks++; if (cnt !== 32'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", cnt); end
  endtask

  task automatic test_load_use();
    idle(); memtoreg_exe = 1; regaddr_exe = 5; use_rt_dec = 1; rt_dec = 5; #2;
    checks++; if ({stall_pc, stall_decode, flush_exe} !== 3'b111) begin errors++; $display("FAIL lw_stall got %b want 111", {stall_pc, stall_decode, flush_exe}); end
    tick(); idle(); #2;
    checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL lw_cnt got %0d want 1", cnt); end
    checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL lw_release got %b want 0", stall_pc); end
    memtoreg_exe = 1; regaddr_exe = 5; use_rt_dec = 0; rt_dec = 5; #2;
    checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL lw_unused got %b want 0", stall_pc); end
    tick();
  endtask

  task automatic test_forwarding();
    idle(); rs_exe = 3; regaddr_mem = 3; regwrite_mem = 1; regaddr_wb = 3; regwrite_wb = 1; #2;
    checks++; if (fa_e !== 2'b10) begin errors++; $display("FAIL fwd_mem got %b want 10", fa_e); end
    regwrite_mem = 0; #2;
    checks++; if (fa_e !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b want 01", fa_e); end
    rs_exe = 0; regwrite_mem = 1; regaddr_mem = 0; regaddr_wb = 0; #2;
    checks++; if (fa_e !== 2'b00) begin errors++; $display("FAIL fwd_zero got %b want 00", fa_e); end
    rt_exe = 4; regaddr_wb = 4; #2;
    checks++; if (fb_e !== 2'b01) begin errors++; $display("FAIL fwdB_wb got %b want 01", fb_e); end
    tick();
  endtask

  task automatic test_branch();
    idle(); branch_dec = 1; rs_dec = 7; regwrite_exe = 1; regaddr_exe = 7; #2;
    checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL br_stall got %b want 1", stall_pc); end
    tick();
    regwrite_exe = 0; regaddr_exe = 0; regaddr_mem = 7; regwrite_mem = 1; memtoreg_mem = 0; #2;
    checks++; if ({stall_pc, fa_d} !== 2'b01) begin errors++; $display("FAIL br_fwd got %b want 01", {stall_pc, fa_d}); end
    tick();
  endtask

  task automatic test_mdu_raw();
    int nbusy;
    idle(); mdu_start_dec = 1; mdu_dst_dec = 9; #2;
    checks++; if ({stall_pc, busy} !== 2'b00) begin errors++; $display("FAIL raw_issue got %b want 00", {stall_pc, busy}); end
    tick(); idle(); use_rs_dec = 1; rs_dec = 9;
    nbusy = 0;
    for (int c = 1; c <= 4; c++) begin
      #2;
      if (busy === 1'b1) nbusy++;
      checks++; if ({stall_pc, done} !== {c <= 3, c == 3}) begin errors++; $display("FAIL raw_c%0d got stall,done=%b want %b", c, {stall_pc, done}, {c <= 3, c == 3}); end
      tick();
    end
    checks++; if (nbusy != LAT - 1) begin errors++; $display("FAIL raw_busy_len got %0d want %0d", nbusy, LAT - 1); end
  endtask

  task automatic test_mdu_struct();
    idle(); mdu_start_dec = 1; mdu_dst_dec = 10; #2; tick();
    mdu_dst_dec = 11;
    for (int c = 1; c <= 3; c++) begin
      #2;
      checks++; if (stall_pc !== (c < 3)) begin errors++; $display("FAIL struct_c%0d got %b want %b", c, stall_pc, c < 3); end
      tick();
    end
    #2;
    checks++; if ({busy, done, wb_addr} !== {2'b10, 5'd11}) begin errors++; $display("FAIL struct_b2b got %b want %b", {busy, done, wb_addr}, {2'b10, 5'd11}); end
    checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL waw got %b want 1", stall_pc); end
    idle(); repeat (3) tick();
    mdu_start_dec = 1; mdu_dst_dec = 0; #2; tick();
    idle(); use_rs_dec = 1; rs_dec = 0; #2;
    checks++; if ({stall_pc, busy} !== 2'b01) begin errors++; $display("FAIL dst0 got %b want 01", {stall_pc, busy}); end
    repeat (3) tick();
  endtask

  task automatic test_flush_issue();
    idle(); mdu_start_dec = 1; mdu_dst_dec = 6; flush_dec = 1; #2; tick(); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_noissue got %b want 0", busy); end
    flush_dec = 0; memtoreg_exe = 1; regaddr_exe = 6; use_rs_dec = 1; rs_dec = 6; #2;
    checks++; if (stall_pc !== 1'b1) begin errors++; $display("FAIL stall_noissue_stall got %b want 1", stall_pc); end
    tick(); idle(); #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_noissue got %b want 0", busy); end
  endtask

  task automatic test_reset_midop();
    idle(); mdu_start_dec = 1; mdu_dst_dec = 12; #2; tick(); idle(); tick();
    rst_n = 0; #2;
    checks++; if ({busy, done, wb_addr, cnt} !== '0) begin errors++; $display("FAIL rst_mid got busy=%b done=%b addr=%0d cnt=%0d want 0", busy, done, wb_addr, cnt); end
    tick(); rst_n = 1; use_rs_dec = 1; rs_dec = 12; #2;
    checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", stall_pc); end
    idle();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_nodone got %b want 0", done); end
    end
  endtask

  task automatic test_saturation();
    idle(); memtoreg_exe = 1; regaddr_exe = 2; use_rs_dec = 1; rs_dec = 2;
    repeat (9) tick();
    idle(); #2;
    checks++; if (cnt !== 32'd9) begin errors++; $display("FAIL sat_cnt32 got %0d want 9", cnt); end
    checks++; if (cnt3 !== 3'd7) begin errors++; $display("FAIL sat_cnt3 got %0d want 7", cnt3); end
  endtask

  task automatic test_random();
    logic [50:0] act, exp;
    for (int i = 0; i < 600; i++) begin
      rs_dec = AW'($urandom_range(7)); rt_dec = AW'($urandom_range(7));
      mdu_dst_dec = AW'($urandom_range(7)); rs_exe = AW'($urandom_range(7));
      rt_exe = AW'($urandom_range(7)); regaddr_exe = AW'($urandom_range(7));
      regaddr_mem = AW'($urandom_range(7)); regaddr_wb = AW'($urandom_range(7));
      {use_rs_dec, use_rt_dec, branch_dec, regwrite_exe, memtoreg_exe} = 5'($urandom);
      {regwrite_mem, memtoreg_mem, regwrite_wb} = 3'($urandom);
      branch_dec = branch_dec & ($urandom_range(3) == 0);
      memtoreg_exe = memtoreg_exe & ($urandom_range(3) == 0);
      mdu_start_dec = $urandom_range(2) == 0;
      flush_dec = $urandom_range(7) == 0;
      #2;
      model_eval();
      act = {stall_pc, stall_decode, flush_exe, fa_d, fb_d, fa_e, fb_e, busy, done, wb_addr, cnt, cnt3};
      exp = {e_stall, e_stall, e_stall, e_fa_d, e_fb_d, e_fa_e, e_fb_e, e_busy, e_done, e_addr, 32'(m_cnt), 3'(m_cnt3)};
      checks++; if (act !== exp) begin errors++; $display("FAIL random_%0d got %h want %h", i, act, exp); end
      tick();
    end
  endtask

  initial begin
    idle();
    repeat (2) tick();
    rst_n = 1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch();
    test_mdu_raw();
    test_mdu_struct();
    test_flush_issue();
    test_reset_midop();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
